// File: rtl/ins_cache_mlines.sv
// ============================================================================
// Module   : ins_cache_mlines
// Brief    : Direct-mapped multi-line instruction cache with DDR burst refill,
//            flush and saturating hit/miss statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_cache_mlines #(
    parameter int ISA_WIDTH         = 30,
    parameter int ADDR_WIDTH_MEM    = 16,
    parameter int DDR_ADDR_WIDTH    = 28,
    parameter int LINE_WORDS        = 32,
    parameter int NUM_LINES         = 4,
    parameter int DDR_BYTES_PER_INS = 8,
    parameter int STAT_WIDTH        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ins_req,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    input  logic                      flush,
    output logic                      ins_cache_rdy,
    output logic [ISA_WIDTH-1:0]      instruction,
    output logic                      ins_valid,
    output logic                      ISA_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    output logic [9:0]                isa_read_len,
    input  logic                      rd_burst_data_valid,
    input  logic [ISA_WIDTH-1:0]      instruction_to_cache,
    output logic [1:0]                st_cur_ins_cache,
    output logic [STAT_WIDTH-1:0]     hit_cnt,
    output logic [STAT_WIDTH-1:0]     miss_cnt
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_WIDTH_MEM - OFF_W - IDX_W;
    localparam int BYTE_SH = $clog2(DDR_BYTES_PER_INS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ISA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] line_valid;

    logic [OFF_W-1:0] beat;
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             flush_pend;

    logic [OFF_W-1:0]          a_off;
    logic [IDX_W-1:0]          a_idx;
    logic [TAG_W-1:0]          a_tag;
    logic [DDR_ADDR_WIDTH-1:0] line_addr;
    logic accept, hit, miss, beat_we, last_beat;

    assign a_off = addr_ins[OFF_W-1:0];
    assign a_idx = addr_ins[OFF_W +: IDX_W];
    assign a_tag = addr_ins[ADDR_WIDTH_MEM-1 -: TAG_W];
    assign line_addr = DDR_ADDR_WIDTH'({a_tag, a_idx, {OFF_W{1'b0}}}) << BYTE_SH;

    // A request seen during the response cycle belongs to the previous fetch.
    // A flush in the same cycle wins over the lookup, so it becomes a miss.
    assign accept    = (state == IDLE) && ins_req && !ins_valid;
    assign hit       = accept && !flush && line_valid[a_idx] && (tag_mem[a_idx] == a_tag);
    assign miss      = accept && !hit;
    assign beat_we   = (state == REFILL) && rd_burst_data_valid;
    assign last_beat = beat_we && (beat == OFF_W'(LINE_WORDS - 1));

    assign isa_read_len     = 10'(LINE_WORDS);
    assign st_cur_ins_cache = state;
    assign ins_cache_rdy    = (state == IDLE) && !ins_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss) state_nxt = REFILL;
            REFILL:  if (last_beat) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (beat_we) data_mem[{req_idx, beat}] <= instruction_to_cache;
        if (last_beat) tag_mem[req_idx] <= req_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid    <= '0;
            beat          <= '0;
            req_off       <= '0;
            req_idx       <= '0;
            req_tag       <= '0;
            flush_pend    <= 1'b0;
            ins_valid     <= 1'b0;
            instruction   <= '0;
            ISA_read_req  <= 1'b0;
            ISA_read_addr <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            ins_valid <= hit || last_beat;

            if (hit) begin
                instruction <= data_mem[{a_idx, a_off}];
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end

            if (miss) begin
                req_off       <= a_off;
                req_idx       <= a_idx;
                req_tag       <= a_tag;
                ISA_read_addr <= line_addr;
                ISA_read_req  <= 1'b1;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end

            if (beat_we) beat <= beat + 1'b1;

            if (last_beat) begin
                ISA_read_req        <= 1'b0;
                line_valid[req_idx] <= 1'b1;
                beat                <= '0;
                // The requested word may be the beat arriving right now.
                instruction <= (req_off == beat) ? instruction_to_cache
                                                 : data_mem[{req_idx, req_off}];
            end

            if (state == IDLE) begin
                if (flush) line_valid <= '0;
            end else if (state == RESP) begin
                if (flush || flush_pend) line_valid <= '0;
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ins_cache_mlines.sv
// ============================================================================
// Module   : tb_ins_cache_mlines
// Brief    : Self-checking bench for ins_cache_mlines with a DDR burst model
//            and an instruction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ins_cache_mlines;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_req = 1'b0;
    logic [15:0] addr_ins = '0;
    logic        flush = 1'b0;
    logic        ins_cache_rdy;
    logic [29:0] instruction;
    logic        ins_valid;
    logic        ISA_read_req;
    logic [27:0] ISA_read_addr;
    logic [9:0]  isa_read_len;
    logic        rd_burst_data_valid = 1'b0;
    logic [29:0] instruction_to_cache = '0;
    logic [1:0]  st_cur_ins_cache;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int passed = 0;
    int total  = 0;
    logic [29:0] sb[$];

    ins_cache_mlines dut (
        .clk                  (clk),
        .rst                  (rst),
        .ins_req              (ins_req),
        .addr_ins             (addr_ins),
        .flush                (flush),
        .ins_cache_rdy        (ins_cache_rdy),
        .instruction          (instruction),
        .ins_valid            (ins_valid),
        .ISA_read_req         (ISA_read_req),
        .ISA_read_addr        (ISA_read_addr),
        .isa_read_len         (isa_read_len),
        .rd_burst_data_valid  (rd_burst_data_valid),
        .instruction_to_cache (instruction_to_cache),
        .st_cur_ins_cache     (st_cur_ins_cache),
        .hit_cnt              (hit_cnt),
        .miss_cnt             (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else passed++;
    endtask

    // Memory image behind the DDR model: word address plus 0x100.
    function automatic logic [29:0] mem_word(input logic [15:0] a);
        return 30'(a) + 30'h100;
    endfunction

    function automatic logic [15:0] line_base(input logic [15:0] a);
        return {a[15:5], 5'b0};
    endfunction

    always @(negedge clk) begin
        if (!rst && ins_valid) begin
            if (sb.size() == 0) check("unexpected_valid", 32'(ins_valid), 32'd0);
            else check("instruction", 32'(instruction), 32'(sb.pop_front()));
        end
    end

    task automatic fetch(input logic [15:0] a, input bit exp_miss,
                         input int flush_beat, input bit flush_req);
        ins_req  = 1'b1;
        addr_ins = a;
        flush    = flush_req;
        sb.push_back(mem_word(a));
        @(posedge clk); #1;
        flush = 1'b0;
        if (!exp_miss) begin
            check("hit_valid", 32'(ins_valid), 32'd1);
            check("hit_no_ddr", 32'(ISA_read_req), 32'd0);
        end else begin
            check("miss_req", 32'(ISA_read_req), 32'd1);
            check("miss_addr", 32'(ISA_read_addr), 32'(line_base(a)) << 3);
            check("refill_state", 32'(st_cur_ins_cache), 32'd1);
            for (int k = 0; k < 32; k++) begin
                rd_burst_data_valid  = 1'b1;
                instruction_to_cache = mem_word(line_base(a) + 16'(k));
                flush = (k == flush_beat);
                @(posedge clk); #1;
                if (k == 16) check("req_held", 32'(ISA_read_req), 32'd1);
            end
            rd_burst_data_valid = 1'b0;
            flush = 1'b0;
            check("resp_valid", 32'(ins_valid), 32'd1);
            check("req_dropped", 32'(ISA_read_req), 32'd0);
        end
        ins_req = 1'b0;
        @(posedge clk); #1;
        check("valid_one_cycle", 32'(ins_valid), 32'd0);
        check("rdy_after", 32'(ins_cache_rdy), 32'd1);
    endtask

    typedef struct {
        logic [15:0] addr;
        bit          miss;
        int          flush_beat;
        logic [15:0] hits;
        logic [15:0] misses;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'h0005, 1'b1, -1, 16'd0, 16'd1};
        vecs[1]  = '{16'h0006, 1'b0, -1, 16'd1, 16'd1};
        vecs[2]  = '{16'h001F, 1'b0, -1, 16'd2, 16'd1};
        vecs[3]  = '{16'h0085, 1'b1, -1, 16'd2, 16'd2};
        vecs[4]  = '{16'h0005, 1'b1, -1, 16'd2, 16'd3};
        vecs[5]  = '{16'h0020, 1'b1, -1, 16'd2, 16'd4};
        vecs[6]  = '{16'h0040, 1'b1, -1, 16'd2, 16'd5};
        vecs[7]  = '{16'h0020, 1'b0, -1, 16'd3, 16'd5};
        vecs[8]  = '{16'h0040, 1'b0, -1, 16'd4, 16'd5};
        vecs[9]  = '{16'h0005, 1'b0, -1, 16'd5, 16'd5};
        vecs[10] = '{16'h0065, 1'b1, 10, 16'd5, 16'd6};
        vecs[11] = '{16'h0065, 1'b1, -1, 16'd5, 16'd7};
        vecs[12] = '{16'h0005, 1'b1, -1, 16'd5, 16'd8};

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 32'(ins_cache_rdy), 32'd1);
        check("rst_valid", 32'(ins_valid), 32'd0);
        check("rst_req", 32'(ISA_read_req), 32'd0);
        check("rst_addr", 32'(ISA_read_addr), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_hits", 32'(hit_cnt), 32'd0);
        check("rst_misses", 32'(miss_cnt), 32'd0);
        check("rst_state", 32'(st_cur_ins_cache), 32'd0);
        check("read_len", 32'(isa_read_len), 32'd32);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            fetch(vecs[i].addr, vecs[i].miss, vecs[i].flush_beat, 1'b0);
            check("hit_cnt", 32'(hit_cnt), 32'(vecs[i].hits));
            check("miss_cnt", 32'(miss_cnt), 32'(vecs[i].misses));
        end

        // Reset in the middle of a refill.
        ins_req  = 1'b1;
        addr_ins = 16'h0045;
        @(posedge clk); #1;
        check("pre_rst_req", 32'(ISA_read_req), 32'd1);
        for (int k = 0; k < 16; k++) begin
            rd_burst_data_valid  = 1'b1;
            instruction_to_cache = mem_word(16'h0040 + 16'(k));
            if (k < 15) begin
                @(posedge clk); #1;
            end
        end
        #3 rst = 1'b1;
        #1;
        check("async_req_drop", 32'(ISA_read_req), 32'd0);
        check("async_rdy", 32'(ins_cache_rdy), 32'd1);
        check("async_state", 32'(st_cur_ins_cache), 32'd0);
        check("async_hits", 32'(hit_cnt), 32'd0);
        check("async_misses", 32'(miss_cnt), 32'd0);
        rd_burst_data_valid = 1'b0;
        ins_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        fetch(16'h0045, 1'b1, -1, 1'b0);
        check("post_rst_misses", 32'(miss_cnt), 32'd1);
        fetch(16'h0046, 1'b0, -1, 1'b0);
        check("post_rst_hits", 32'(hit_cnt), 32'd1);

        // Flush in the same cycle as a request turns it into a miss.
        fetch(16'h0047, 1'b1, -1, 1'b1);
        check("flush_req_misses", 32'(miss_cnt), 32'd2);
        fetch(16'h0047, 1'b0, -1, 1'b0);
        check("flush_req_hits", 32'(hit_cnt), 32'd2);

        // Standalone flush in IDLE; counters are preserved.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_keeps_hits", 32'(hit_cnt), 32'd2);
        fetch(16'h0047, 1'b1, -1, 1'b0);
        check("idle_flush_misses", 32'(miss_cnt), 32'd3);

        @(posedge clk); #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
